flash_read_scheduler: RTL and testbench
=======================================

// Module: flash_read_scheduler
// PURPOSE
//  Sequences Avalon-MM reads from the audio flash and feeds 8-bit samples to the audio path.
//  Holds a 2-word buffer (cur + prefetch nxt); serves one byte per sample_tick; walks forward/reverse with wrap.
//  Sits between the flash controller master port and the audio output / sample-rate divider.
// PARAMETERS
//  BASE        0        first word address of the audio region
//  MAX_OFFSET  16'h7FFF last valid word offset; region = BASE..BASE+MAX_OFFSET
//  ADDR_W      23       flash word-address width
// PORTS
//  fetch_clock              in   1       sole clock
//  reset                    in   1       asynchronous, active-low reset
//  flash_mem_read           out  1       Avalon read request
//  flash_mem_address        out  ADDR_W  Avalon word address
//  flash_mem_byteenable     out  4       constant 4'hF
//  flash_mem_waitrequest    in   1       slave stall; request held while high
//  flash_mem_readdata       in   32      read data
//  flash_mem_readdatavalid  in   1       readdata qualifier
//  sample_tick              in   1       1-cycle pulse per audio sample
//  play                     in   1       1 = consume/fetch, 0 = pause
//  reverse                  in   1       1 = byte order descending
//  restart                  in   1       1-cycle pulse: flush, go to region start
//  audio_out                out  8       current sample, held between ticks
//  audio_valid              out  1       1-cycle pulse when audio_out updates
//  underrun                 out  1       1-cycle pulse: tick with empty buffer
//  busy                     out  1       fetch FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; cur/nxt invalid; play pos = BASE byte 0; fetch_addr = BASE; flush = 0.
//  Position: word offset 0..MAX_OFFSET + byte 0..3. Fwd: byte+1; after byte 3 -> word+1, byte 0;
//   offset MAX_OFFSET+1 wraps to 0. Rev: byte-1; after byte 0 -> word-1, byte 3; offset -1 wraps to MAX_OFFSET.
//  Fetch FSM IDLE/REQ/WAIT:
//   IDLE: play && (!cur_valid || !nxt_valid) -> REQ, drive address = fetch_addr.
//   REQ: flash_mem_read=1, address stable until cycle with waitrequest=0 -> WAIT, read deasserted next cycle.
//   WAIT: readdatavalid -> store (cur if empty after this cycle's consume, else nxt), fetch_addr steps
//    one word in current direction, -> IDLE. If flush set: data dropped, flush cleared, fetch_addr unchanged.
//   Max one outstanding read. A request in REQ is never withdrawn (Avalon rule), even on restart/reset-free events.
//  Consume (sample_tick && play):
//   cur_valid: audio_out <= cur[8*byte+7 -: 8], audio_valid=1 next cycle (latency 1); advance position;
//    on word crossing cur <= nxt (if nxt_valid) else cur_valid=0; nxt_valid=0.
//   !cur_valid: underrun=1 next cycle; audio_out held; position unchanged.
//   play=0: ticks ignored (no underrun); no new REQ; outstanding read completes and is stored.
//  Reverse toggle (edge of reverse): nxt invalidated; fetch_addr = cur word +/-1 (new dir, wrapped);
//   if cur invalid, fetch_addr = play word; read in REQ/WAIT -> flush=1. Byte index unchanged.
//  restart: cur/nxt invalid; pos = BASE byte 0 (fwd) or BASE+MAX_OFFSET byte 3 (rev); fetch_addr = that word;
//   in-flight read flushed. restart has priority over a same-cycle tick; tick ignored.
//  Same-cycle readdatavalid + crossing tick with nxt empty: new word lands in cur, no underrun.
//  busy = (state != IDLE).
// STRUCTURE
//  flash_fetch_pkg: fetch_state_e {IDLE,REQ,WAIT}; ADDR_W; BYTES_PER_WORD=4.
//  Sub-module flash_addr_step: combinational {word,byte,reverse} -> next {word,byte,crossed} with wrap;
//   instantiated twice (play position, fetch_addr word step).
// TESTING
//  1 Reset, play=1, waitrequest=0, 1-cycle data latency, word@BASE=32'h44332211 -> ticks give 11,22,33,44.
//  2 waitrequest held high 5 cycles -> read and address stable all 5; one read accepted; no duplicate.
//  3 MAX_OFFSET=3, fwd, 16 ticks -> last byte of word 3 then byte 0 of word BASE (wrap).
//  4 Reverse at cur=word 2 byte 1 with nxt=word 3 -> next bytes word2 b0, then word1 b3; word 3 never emitted.
//  5 Hold readdatavalid off, 3 ticks -> 3 underrun pulses, audio_out held, no audio_valid.
//  6 restart while in WAIT -> returned data discarded; next read address = BASE; first byte = BASE b0.

Source files
------------

// File: rtl/flash_fetch_pkg.sv
// Shared types and constants for the audio flash read scheduler.
package flash_fetch_pkg;
   localparam int ADDR_W         = 23;
   localparam int OFF_W          = 16;
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_W         = $clog2(BYTES_PER_WORD);
   localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_WORD - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_e;
endpackage

// File: rtl/flash_addr_step.sv
// One step of a {word, byte} position through the audio region, forward or reverse, with wrap.
module flash_addr_step
   import flash_fetch_pkg::*;
#(
   parameter logic [OFF_W-1:0] MAX_OFFSET = 16'h7FFF
) (
   input  logic [OFF_W-1:0]  i_word,
   input  logic [BYTE_W-1:0] i_byte,
   input  logic              i_reverse,
   output logic [OFF_W-1:0]  o_word,
   output logic [BYTE_W-1:0] o_byte,
   output logic              o_crossed
);
   always_comb begin
      // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
      o_word    = i_word;
      o_byte    = i_byte;
      o_crossed = 1'b0;
      if (i_reverse) begin
         if (i_byte == '0) begin
            o_crossed = 1'b1;
            o_byte    = LAST_BYTE;
            o_word    = (i_word == '0) ? MAX_OFFSET : i_word - OFF_W'(1);
         end else begin
            o_byte = i_byte - BYTE_W'(1);
         end
      end else begin
         if (i_byte == LAST_BYTE) begin
            o_crossed = 1'b1;
            o_byte    = '0;
            o_word    = (i_word == MAX_OFFSET) ? '0 : i_word + OFF_W'(1);
         end else begin
            o_byte = i_byte + BYTE_W'(1);
         end
      end
   end
endmodule

// File: rtl/flash_read_scheduler.sv
// Prefetches 32-bit words from the audio flash into a cur/nxt pair and hands out one byte per sample tick.
module flash_read_scheduler #(
   parameter int                                ADDR_W     = flash_fetch_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0]                 BASE       = '0,
   parameter logic [flash_fetch_pkg::OFF_W-1:0] MAX_OFFSET = 16'h7FFF
) (
   input  logic              fetch_clock,
   input  logic              reset,
   output logic              flash_mem_read,
   output logic [ADDR_W-1:0] flash_mem_address,
   output logic [3:0]        flash_mem_byteenable,
   input  logic              flash_mem_waitrequest,
   input  logic [31:0]       flash_mem_readdata,
   input  logic              flash_mem_readdatavalid,
   input  logic              sample_tick,
   input  logic              play,
   input  logic              reverse,
   input  logic              restart,
   output logic [7:0]        audio_out,
   output logic              audio_valid,
   output logic              underrun,
   output logic              busy
);
   import flash_fetch_pkg::*;

   fetch_state_e      r_state;
   logic              r_read;
   logic [ADDR_W-1:0] r_addr;
   logic              r_flush;
   logic              r_reverse_d;
   logic [OFF_W-1:0]  r_fetch_off;
   logic [OFF_W-1:0]  r_play_off;
   logic [BYTE_W-1:0] r_play_byte;
   logic              r_cur_valid;
   logic              r_nxt_valid;
   logic [31:0]       r_cur_data;
   logic [31:0]       r_nxt_data;
   logic [7:0]        r_audio;
   logic              r_audio_valid;
   logic              r_underrun;

   logic [OFF_W-1:0]  w_pstep_word;
   logic [BYTE_W-1:0] w_pstep_byte;
   logic              w_pstep_cross;
   logic [OFF_W-1:0]  w_fstep_in;
   logic [OFF_W-1:0]  w_fstep_word;
   logic [BYTE_W-1:0] w_fstep_byte;
   logic              w_fstep_cross;

   logic w_rev_edge, w_tick, w_consume, w_cross, w_shift;
   logic w_accept, w_cur_empty_after, w_store_cur, w_store_nxt;
   logic [OFF_W-1:0]  w_start_off;
   logic [BYTE_W-1:0] w_start_byte;
   logic [OFF_W-1:0]  w_toggle_off;
   logic [7:0]        w_cur_byte;
   logic              w_unused;

   assign w_rev_edge   = reverse ^ r_reverse_d;
   assign w_tick       = sample_tick && play && !restart;
   assign w_consume    = w_tick && r_cur_valid;
   assign w_cross      = w_consume && w_pstep_cross;
   // A nxt word fetched for the old direction must not slide into cur on a toggle.
   assign w_shift      = w_cross && r_nxt_valid && !w_rev_edge;
   assign w_accept     = (r_state == WAIT) && flash_mem_readdatavalid && !r_flush && !restart && !w_rev_edge;
   assign w_cur_empty_after = !r_cur_valid || (w_cross && !r_nxt_valid);
   assign w_store_cur  = w_accept && w_cur_empty_after;
   assign w_store_nxt  = w_accept && !w_cur_empty_after;
   assign w_start_off  = reverse ? MAX_OFFSET : '0;
   assign w_start_byte = reverse ? LAST_BYTE : '0;
   assign w_fstep_in   = w_rev_edge ? r_play_off : r_fetch_off;
   assign w_toggle_off = r_cur_valid ? w_fstep_word : r_play_off;
   assign w_cur_byte   = r_cur_data[{r_play_byte, 3'b000} +: 8];
   assign w_unused     = &{1'b0, w_fstep_byte, w_fstep_cross};

   flash_addr_step #(.MAX_OFFSET(MAX_OFFSET)) u_play_step (
      .i_word    (r_play_off),
      .i_byte    (r_play_byte),
      .i_reverse (reverse),
      .o_word    (w_pstep_word),
      .o_byte    (w_pstep_byte),
      .o_crossed (w_pstep_cross)
   );

   // Feeding the edge byte forces a word crossing, so this instance is a pure word step.
   flash_addr_step #(.MAX_OFFSET(MAX_OFFSET)) u_fetch_step (
      .i_word    (w_fstep_in),
      .i_byte    (reverse ? '0 : LAST_BYTE),
      .i_reverse (reverse),
      .o_word    (w_fstep_word),
      .o_byte    (w_fstep_byte),
      .o_crossed (w_fstep_cross)
   );

   always_ff @(posedge fetch_clock or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_read      <= 1'b0;
         r_addr      <= '0;
         r_flush     <= 1'b0;
         r_fetch_off <= '0;
         r_reverse_d <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge state.
         r_reverse_d <= reverse;
         case (r_state)
            IDLE: begin
               if (play && !restart && !w_rev_edge && (!r_cur_valid || !r_nxt_valid)) begin
                  r_state <= REQ;
                  r_read  <= 1'b1;
                  r_addr  <= BASE + ADDR_W'(r_fetch_off);
               end
            end
            REQ: begin
               if (!flash_mem_waitrequest) begin
                  r_read  <= 1'b0;
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (flash_mem_readdatavalid) begin
                  r_state <= IDLE;
                  if (r_flush) begin
                     r_flush <= 1'b0;
                  end else if (!restart && !w_rev_edge) begin
                     r_fetch_off <= w_fstep_word;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
         if (restart || w_rev_edge) begin
            r_fetch_off <= restart ? w_start_off : w_toggle_off;
            if (r_state == REQ || (r_state == WAIT && !flash_mem_readdatavalid)) begin
               r_flush <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge fetch_clock or negedge reset) begin
      if (!reset) begin
         r_cur_valid   <= 1'b0;
         r_nxt_valid   <= 1'b0;
         r_play_off    <= '0;
         r_play_byte   <= '0;
         r_audio       <= '0;
         r_audio_valid <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_audio_valid <= w_consume;
         r_underrun    <= w_tick && !r_cur_valid;
         if (w_consume) begin
            r_audio     <= w_cur_byte;
            r_play_off  <= w_pstep_word;
            r_play_byte <= w_pstep_byte;
         end
         if (restart) begin
            r_cur_valid <= 1'b0;
            r_nxt_valid <= 1'b0;
            r_play_off  <= w_start_off;
            r_play_byte <= w_start_byte;
         end else begin
            if (w_store_cur) begin
               r_cur_valid <= 1'b1;
            end else if (w_cross && !w_shift) begin
               r_cur_valid <= 1'b0;
            end
            if (w_rev_edge) begin
               r_nxt_valid <= 1'b0;
            end else if (w_store_nxt) begin
               r_nxt_valid <= 1'b1;
            end else if (w_cross) begin
               r_nxt_valid <= 1'b0;
            end
         end
      end
   end

   // NOTE: the data words have no reset; their valid flags alone say whether they hold anything.
   always_ff @(posedge fetch_clock) begin
      if (w_store_cur) begin
         r_cur_data <= flash_mem_readdata;
      end else if (w_shift) begin
         r_cur_data <= r_nxt_data;
      end
      if (w_store_nxt) begin
         r_nxt_data <= flash_mem_readdata;
      end
   end

   assign flash_mem_read       = r_read;
   assign flash_mem_address    = r_addr;
   assign flash_mem_byteenable = 4'hF;
   assign audio_out            = r_audio;
   assign audio_valid          = r_audio_valid;
   assign underrun             = r_underrun;
   assign busy                 = (r_state != IDLE);
endmodule

// File: tb/tb_flash_read_scheduler.sv
// Directed bench: a 4-word region at 0x100 behind a flash slave model with configurable stall and data hold.
module tb_flash_read_scheduler;
   localparam int                AW   = 23;
   localparam logic [AW-1:0]     BASE = 23'h100;
   localparam logic [15:0]       MAXO = 16'd3;

   logic          clk, rst_n;
   logic          flash_mem_read;
   logic [AW-1:0] flash_mem_address;
   logic [3:0]    flash_mem_byteenable;
   logic          waitrequest, readdatavalid;
   logic [31:0]   readdata;
   logic          sample_tick, play, reverse, restart;
   logic [7:0]    audio_out;
   logic          audio_valid, underrun, busy;

   int n_cmp = 0, n_fail = 0;
   int stall_cfg = 0, stall_obs = 0, stall_bad = 0, n_accept = 0;
   bit rdv_block = 0;
   logic [AW-1:0] acc_q[$];

   typedef struct {
      bit         rev;
      int         gap;
      bit         ev;
      bit         eu;
      logic [7:0] ea;
   } vec_t;
   vec_t vecs[36];

   flash_read_scheduler #(.ADDR_W(AW), .BASE(BASE), .MAX_OFFSET(MAXO)) dut (
      .fetch_clock             (clk),
      .reset                   (rst_n),
      .flash_mem_read          (flash_mem_read),
      .flash_mem_address       (flash_mem_address),
      .flash_mem_byteenable    (flash_mem_byteenable),
      .flash_mem_waitrequest   (waitrequest),
      .flash_mem_readdata      (readdata),
      .flash_mem_readdatavalid (readdatavalid),
      .sample_tick             (sample_tick),
      .play                    (play),
      .reverse                 (reverse),
      .restart                 (restart),
      .audio_out               (audio_out),
      .audio_valid             (audio_valid),
      .underrun                (underrun),
      .busy                    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte b of word w: word 0 is 44332211, each later word adds 0x40 per byte.
   function automatic logic [7:0] exp_byte(input int w, input int b);
      return 8'(17 * (b + 1) + 64 * w);
   endfunction

   function automatic logic [31:0] word_data(input int w);
      return {exp_byte(w, 3), exp_byte(w, 2), exp_byte(w, 1), exp_byte(w, 0)};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic do_tick(input int gap, input bit ev, input bit eu, input logic [7:0] ea, input string nm);
      repeat (gap) @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      check(nm, {22'd0, audio_valid, underrun, audio_out}, {22'd0, ev, eu, ea});
   endtask

   task automatic add_vec(inout int n, input bit rev, input int w, input int b);
      vecs[n].rev = rev;
      vecs[n].gap = 8;
      vecs[n].ev  = 1'b1;
      vecs[n].eu  = 1'b0;
      vecs[n].ea  = exp_byte(w, b);
      n++;
   endtask

   // Slave model: decides waitrequest/readdatavalid on the falling edge for the next rising edge.
   initial begin : flash_slave
      int            stall_left;
      logic [AW-1:0] hold_addr;
      logic [AW-1:0] rsp_addr;
      bit            acc_now, rsp_pend;
      stall_left = -1;
      hold_addr  = '0;
      rsp_addr   = '0;
      acc_now    = 1'b0;
      rsp_pend   = 1'b0;
      waitrequest   = 1'b0;
      readdatavalid = 1'b0;
      readdata      = '0;
      forever begin
         @(negedge clk);
         readdatavalid = 1'b0;
         if (acc_now) begin
            acc_now  = 1'b0;
            rsp_pend = 1'b1;
         end
         if (rsp_pend && !rdv_block) begin
            readdatavalid = 1'b1;
            readdata      = word_data(int'(rsp_addr - BASE));
            rsp_pend      = 1'b0;
         end
         if (flash_mem_read) begin
            if (stall_left < 0) begin
               stall_left = stall_cfg;
               hold_addr  = flash_mem_address;
            end
            if (flash_mem_address !== hold_addr) stall_bad++;
            if (stall_left > 0) begin
               waitrequest = 1'b1;
               stall_left--;
               stall_obs++;
            end else begin
               waitrequest = 1'b0;
               acc_now     = 1'b1;
               rsp_addr    = flash_mem_address;
               acc_q.push_back(flash_mem_address);
               n_accept++;
               stall_left  = -1;
            end
         end else begin
            waitrequest = 1'b0;
         end
      end
   end

   initial begin : stimulus
      int n, w, b, acc0, acc1;
      n = 0;
      for (int i = 0; i < 25; i++) add_vec(n, 1'b0, (i / 4) % 4, i % 4);
      w = 2;
      b = 1;
      for (int k = 0; k < 11; k++) begin
         add_vec(n, 1'b1, w, b);
         if (b == 0) begin
            b = 3;
            w = (w == 0) ? 3 : w - 1;
         end else begin
            b = b - 1;
         end
      end

      sample_tick = 1'b0;
      play        = 1'b0;
      reverse     = 1'b0;
      restart     = 1'b0;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_read",    {31'd0, flash_mem_read}, 32'd0);
      check("rst_busy",    {31'd0, busy}, 32'd0);
      check("rst_audio",   {22'd0, audio_valid, underrun, audio_out}, 32'd0);
      check("rst_addr",    {9'd0, flash_mem_address}, 32'd0);
      check("byteenable",  {28'd0, flash_mem_byteenable}, 32'hF);
      do_tick(2, 1'b0, 1'b0, 8'h00, "paused_tick");

      // Forward through the region with wrap, then a reverse toggle at word 2 and a reverse wrap.
      play = 1'b1;
      for (int i = 0; i < n; i++) begin
         reverse = vecs[i].rev;
         do_tick(vecs[i].gap, vecs[i].ev, vecs[i].eu, vecs[i].ea, $sformatf("vec%0d", i));
      end

      play = 1'b0;
      repeat (10) @(negedge clk);
      reverse = 1'b0;
      repeat (10) @(negedge clk);

      // Five stall cycles on the first read after restart.
      stall_cfg = 5;
      stall_obs = 0;
      stall_bad = 0;
      acc0      = n_accept;
      play      = 1'b1;
      restart   = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      @(negedge clk);
      check("stall_read", {31'd0, flash_mem_read}, 32'd1);
      check("stall_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
      play = 1'b0;
      repeat (15) @(negedge clk);
      check("stall_cycles",   stall_obs, 32'd5);
      check("stall_addr_bad", stall_bad, 32'd0);
      check("stall_accepts",  n_accept - acc0, 32'd1);
      check("stall_acc_addr", {9'd0, acc_q[acc0]}, {9'd0, BASE});
      check("stall_idle",     {31'd0, busy}, 32'd0);
      stall_cfg = 0;

      // Data held back: word 0 drains, then three underruns with audio_out held.
      rdv_block = 1'b1;
      play      = 1'b1;
      for (int i = 0; i < 4; i++) do_tick(4, 1'b1, 1'b0, exp_byte(0, i), $sformatf("drain_b%0d", i));
      for (int i = 0; i < 3; i++) do_tick(3, 1'b0, 1'b1, 8'h44, $sformatf("underrun%0d", i));
      rdv_block = 1'b0;
      do_tick(6, 1'b1, 1'b0, exp_byte(1, 0), "resume_w1b0");
      repeat (6) @(negedge clk);

      // Restart while a read sits in WAIT: its data must be dropped and the region refetched from BASE.
      rdv_block = 1'b1;
      for (int i = 1; i < 4; i++) do_tick(3, 1'b1, 1'b0, exp_byte(1, i), $sformatf("pre_rst_b%0d", i));
      repeat (5) @(negedge clk);
      check("wait_busy", {31'd0, busy}, 32'd1);
      acc1    = n_accept;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      repeat (3) @(negedge clk);
      rdv_block = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_refetch_addr", {9'd0, acc_q[acc1]}, {9'd0, BASE});
      do_tick(2, 1'b1, 1'b0, exp_byte(0, 0), "rst_first_byte");
      do_tick(4, 1'b1, 1'b0, exp_byte(0, 1), "rst_second_byte");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
